dist_ram_bist: RTL and testbench

- Memory built-in self-test initiator that drives the en/we/addr/din side of a single-port distributed RAM and checks its dout.
- Runs a March C- style sequence over every address and reports pass/fail, the first failing address/data, and an error count.
- Sits beside each dist_ram instance; its ram_* ports connect directly to the RAM's en/we/addr/din/dout.
- Relies on the RAM being read-first with 1-cycle registered read latency: when en=1, dout updates at the next clk edge to the pre-write contents of addr.

---
 rtl/dist_ram_bist.sv | 137 +++++++++++++
 tb/tb_dist_ram_bist.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dist_ram_bist.sv
// March C- BIST for a read-first, 1-cycle-latency single-port RAM: runs 4N+1 busy cycles per start,
// with each read checked one cycle after it is issued; start is ignored while busy.
module dist_ram_bist #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 4,
  parameter logic [63:0] BACKGROUND = 64'h55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH+1:0] err_count
);

  localparam logic [DATA_WIDTH-1:0] PAT  = DATA_WIDTH'(BACKGROUND);
  localparam logic [ADDR_WIDTH-1:0] AMAX = '1;

  typedef enum logic [2:0] {IDLE, W_BG, RW_UP, RW_DN, R_UP, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_issue, accept;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic                  chk_vld;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [DATA_WIDTH-1:0] chk_exp;
  logic                  fail_flag;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_din  = '0;
    rd_issue = 1'b0;
    rd_exp   = '0;
    accept   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = W_BG;
          addr_d  = '0;
        end
      end
      W_BG: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        ram_din = PAT;
        addr_d  = addr_q + 1'b1;
        if (addr_q == AMAX) state_d = RW_UP;
      end
      RW_UP: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_din  = ~PAT;
        rd_issue = 1'b1;
        rd_exp   = PAT;
        addr_d   = addr_q + 1'b1;
        if (addr_q == AMAX) begin
          state_d = RW_DN;
          addr_d  = AMAX;
        end
      end
      RW_DN: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_din  = PAT;
        rd_issue = 1'b1;
        rd_exp   = ~PAT;
        addr_d   = addr_q - 1'b1;
        if (addr_q == '0) begin
          state_d = R_UP;
          addr_d  = '0;
        end
      end
      R_UP: begin
        ram_en   = 1'b1;
        rd_issue = 1'b1;
        rd_exp   = PAT;
        addr_d   = addr_q + 1'b1;
        if (addr_q == AMAX) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr = ram_en ? addr_q : '0;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      chk_vld   <= 1'b0;
      chk_addr  <= '0;
      chk_exp   <= '0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_flag <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      chk_vld  <= rd_issue;
      chk_addr <= addr_q;
      chk_exp  <= rd_exp;
      if (accept) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_flag <= 1'b0;
      end else if (chk_vld && (ram_dout != chk_exp)) begin
        // Only the first mismatch of a run is captured for diagnosis.
        err_count <= err_count + (ADDR_WIDTH+2)'(1);
        if (!fail_flag) begin
          fail_addr <= chk_addr;
          fail_data <= ram_dout;
          fail_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dist_ram_bist.sv
// Bench for dist_ram_bist: behavioural read-first RAMs with injectable faults, directed runs.
module tb_dist_ram_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start2;
  logic       ram_en, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       busy, done, pass;
  logic [3:0] fail_addr;
  logic [7:0] fail_data;
  logic [5:0] err_count;

  logic       en2, we2;
  logic [1:0] addr2;
  logic [3:0] din2, dout2;
  logic       busy2, done2, pass2;
  logic [1:0] faddr2;
  logic [3:0] fdata2;
  logic [3:0] err2;

  always #5 clk = ~clk;

  dist_ram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count)
  );

  dist_ram_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .BACKGROUND(4'hA)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .ram_en(en2), .ram_we(we2), .ram_addr(addr2), .ram_din(din2),
    .ram_dout(dout2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(faddr2), .fail_data(fdata2), .err_count(err2)
  );

  // RAM models: read-first, registered read. fault 1 = addr 5 bit 0 stuck at 1, fault 2 = addr 9 reads 0.
  logic [7:0] mem [16];
  logic [3:0] mem2 [4];
  int         fault = 0;
  logic       log_on = 1'b0;
  logic [3:0] addr_log [$];
  logic [3:0] wr2_log [$];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem2[i] = 4'h0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= (fault == 2 && ram_addr == 4'd9) ? 8'h00 :
                  (fault == 1 && ram_addr == 4'd5) ? (mem[ram_addr] | 8'h01) : mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
      if (log_on) addr_log.push_back(ram_addr);
    end
    if (en2) begin
      dout2 <= mem2[addr2];
      if (we2) begin
        mem2[addr2] <= din2;
        wr2_log.push_back(din2);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         fmode;
    bit         repulse;
    int         cycles;
    logic       pass;
    logic [5:0] err;
    logic [3:0] faddr;
    logic [7:0] fdata;
  } vec_t;

  vec_t vecs [4];

  // Pulses start, then counts the cycles busy stays high (bounded).
  task automatic run(input bit repulse, output int cycles);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("clear_on_start", {done, err_count}, 7'd0);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      start = repulse && (cycles == 10 || cycles == 40);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int         cyc;
    logic [3:0] exp_addr [$];
    logic [3:0] exp_wr [$];
    int         bad;

    vecs[0] = '{0, 1'b0, 65, 1'b1, 6'd0, 4'd0, 8'h00};
    vecs[1] = '{1, 1'b0, 65, 1'b0, 6'd1, 4'd5, 8'hAB};  // RW_DN read at 5 sees AA|1; R_UP reads 55 intact
    vecs[2] = '{2, 1'b0, 65, 1'b0, 6'd3, 4'd9, 8'h00};
    vecs[3] = '{0, 1'b1, 65, 1'b1, 6'd0, 4'd0, 8'h00};

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ram_en, ram_we, busy, done, pass, err_count, fail_addr, fail_data}, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      fault = vecs[v].fmode;
      addr_log.delete();
      log_on = (v == 0);
      run(vecs[v].repulse, cyc);
      log_on = 1'b0;
      chk($sformatf("v%0d_busy_cycles", v), cyc, vecs[v].cycles);
      chk($sformatf("v%0d_done", v), done, 1'b1);
      chk($sformatf("v%0d_pass", v), pass, vecs[v].pass);
      chk($sformatf("v%0d_err_count", v), err_count, vecs[v].err);
      chk($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].faddr);
      chk($sformatf("v%0d_fail_data", v), fail_data, vecs[v].fdata);
      if (v == 0) begin
        for (int a = 0; a < 16; a++) exp_addr.push_back(4'(a));
        for (int a = 0; a < 16; a++) exp_addr.push_back(4'(a));
        for (int a = 15; a >= 0; a--) exp_addr.push_back(4'(a));
        for (int a = 0; a < 16; a++) exp_addr.push_back(4'(a));
        bad = 0;
        for (int i = 0; i < 64; i++)
          if (i >= addr_log.size() || addr_log[i] !== exp_addr[i]) bad++;
        chk("addr_seq_len", addr_log.size(), 64);
        chk("addr_seq_mismatches", bad, 0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_results_hold", v), {done, err_count}, {1'b1, vecs[v].err});
    end

    // Reset 30 cycles into a run aborts it.
    fault = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", {ram_en, busy, done}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_stays_idle", {ram_en, busy}, 2'b00);
    run(1'b0, cyc);
    chk("after_abort_cycles", cyc, 65);
    chk("after_abort_pass", {done, pass, err_count}, {2'b11, 6'd0});

    // Narrow instance: N=4, P=A.
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("small_busy_cycles", cyc, 17);
    chk("small_done_pass", {done2, pass2, err2}, {2'b11, 4'd0});
    for (int i = 0; i < 4; i++) exp_wr.push_back(4'hA);
    for (int i = 0; i < 4; i++) exp_wr.push_back(4'h5);
    for (int i = 0; i < 4; i++) exp_wr.push_back(4'hA);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (i >= wr2_log.size() || wr2_log[i] !== exp_wr[i]) bad++;
    chk("small_write_count", wr2_log.size(), 12);
    chk("small_write_data", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
